scan_chain_mc: RTL

Parametrised multi-chain scan register with a built-in scan test sequencer. It is the successor to the fixed 8-flop single scan chain. It holds CHAINS independent chains of WIDTH flops each and supports three modes: functional load, manual shift, and an autonomous shift-in / capture / shift-out test sequence. It sits between functional logic and the scan I/O pins.

---
 rtl/scan_chain_mc_if.sv | 29 ++
 rtl/scan_chain_mc.sv | 106 ++++++++++
 2 files changed

// File: rtl/scan_chain_mc_if.sv
// Signal bundle for scan_chain_mc: functional/capture data, scan controls and status.
interface scan_chain_mc_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CHAINS = 4
);
   localparam int unsigned CntW = $clog2(WIDTH);

   logic                      mode;
   logic [CHAINS*WIDTH-1:0]   func_d;
   logic                      scan_en;
   logic [CHAINS-1:0]         scan_in;
   logic                      test_start;
   logic [CHAINS*WIDTH-1:0]   q_out;
   logic [CHAINS-1:0]         scan_out;
   logic                      busy;
   logic                      capture;
   logic                      done;
   logic [CntW-1:0]           shift_cnt;

   modport master (
      output mode, func_d, scan_en, scan_in, test_start,
      input  q_out, scan_out, busy, capture, done, shift_cnt
   );

   modport slave (
      input  mode, func_d, scan_en, scan_in, test_start,
      output q_out, scan_out, busy, capture, done, shift_cnt
   );
endinterface

// File: rtl/scan_chain_mc.sv
// Multi-chain scan register with an autonomous shift-in / capture / shift-out sequencer.
module scan_chain_mc #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CHAINS = 4
) (
   input logic             clk,
   input logic             rst_n,
   scan_chain_mc_if.slave  bus
);
   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StShiftIn,
      StCapture,
      StShiftOut,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [CHAINS*WIDTH-1:0] q_q, q_d;
   logic [CHAINS*WIDTH-1:0] shifted;
   logic [CntW-1:0]         cnt_q, cnt_d;

   // All chains advance together; each takes its own serial bit into position 0.
   always_comb begin
      shifted = '0;
      for (int c = 0; c < int'(CHAINS); c++) begin
         shifted[c*WIDTH +: WIDTH] = {q_q[c*WIDTH +: WIDTH-1], bus.scan_in[c]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         q_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (!bus.mode) begin
               q_d = bus.func_d;
            end else if (bus.test_start) begin
               state_d = StShiftIn;
               cnt_d   = '0;
            end else if (bus.scan_en) begin
               q_d = shifted;
            end
         end
         StShiftIn: begin
            q_d = shifted;
            if (cnt_q == CntMax) begin
               state_d = StCapture;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCapture: begin
            q_d     = bus.func_d;
            state_d = StShiftOut;
         end
         StShiftOut: begin
            q_d = shifted;
            if (cnt_q == CntMax) begin
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      bus.scan_out = '0;
      for (int c = 0; c < int'(CHAINS); c++) begin
         bus.scan_out[c] = q_q[c*WIDTH + WIDTH - 1];
      end
   end

   assign bus.q_out     = q_q;
   assign bus.shift_cnt = cnt_q;
   assign bus.busy      = (state_q == StShiftIn) || (state_q == StCapture) ||
                          (state_q == StShiftOut);
   assign bus.capture   = (state_q == StCapture);
   assign bus.done      = (state_q == StDone);
endmodule
